// File: rtl/adc_axis_pkg.sv
// Shared types and helpers for the multi-channel ADC-to-AXIS packetizer.
package adc_axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cap_state_e;

    // Address width for a FIFO of n entries, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : int'($clog2(n));
    endfunction

    function automatic int unsigned beat_w(input int unsigned num_ch, input int unsigned ch_width);
        return num_ch * ch_width;
    endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous beat FIFO; full/empty/level are registered so the writer sees a stable occupancy.
module adc_sample_fifo
    import adc_axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 33,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           rd_en,
    output logic [DATA_WIDTH-1:0]          rd_data_c,
    output logic                           full,
    output logic                           empty,
    output logic [clog2_min1(DEPTH):0]     level
);
    localparam int unsigned AW = clog2_min1(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           level_d;
    logic                  wr_ok;
    logic                  rd_ok;

    assign wr_ok     = wr_en && !full;
    assign rd_ok     = rd_en && !empty;
    assign rd_data_c = mem[rd_ptr];

    always_comb begin
        level_d = level;
        case ({wr_ok, rd_ok})
            2'b10:   level_d = level + (AW+1)'(1);
            2'b01:   level_d = level - (AW+1)'(1);
            default: level_d = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            level <= level_d;
            full  <= (level_d == (AW+1)'(DEPTH));
            empty <= (level_d == '0);
        end
    end

endmodule

// File: rtl/adc_axis_packetizer.sv
// Packs NUM_CH ADC samples per beat, frames them into fixed-length AXIS packets
// and buffers them in a FIFO; supports continuous and one-shot capture.
module adc_axis_packetizer
    import adc_axis_pkg::*;
#(
    parameter int unsigned CH_WIDTH   = 16,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                          m_axis_aclk,
    input  logic                          m_axis_aresetn,
    input  logic [NUM_CH*CH_WIDTH-1:0]    i_adc_data,
    input  logic                          i_adc_valid,
    input  logic                          i_con_adcside,
    input  logic                          i_con_axisside,
    input  logic                          i_mode,
    input  logic                          i_arm,
    input  logic [LEN_WIDTH-1:0]          i_pkt_len,
    output logic                          m_axis_tvalid,
    output logic [NUM_CH*CH_WIDTH-1:0]    m_axis_tdata,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow,
    output logic [LEN_WIDTH-1:0]          o_drop_count,
    output logic                          o_busy
);
    localparam int unsigned DW = beat_w(NUM_CH, CH_WIDTH);
    localparam int unsigned FW = DW + 1;

    cap_state_e          state_q;
    cap_state_e          state_d;
    logic [DW-1:0]       adc_data_q;
    logic                adc_valid_q;
    logic                con_adc_q;
    logic                mode_q;
    logic                arm_q;
    logic [LEN_WIDTH-1:0] pkt_len_q;
    logic [LEN_WIDTH-1:0] cnt_q;
    logic [LEN_WIDTH-1:0] len_q;

    logic [LEN_WIDTH-1:0] len_eff_c;
    logic [LEN_WIDTH-1:0] cur_len_c;
    logic                 last_c;
    logic                 stop_c;
    logic                 take_c;
    logic                 accept_c;
    logic                 drop_c;
    logic                 load_c;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FW-1:0]        fifo_rd_c;

    // Input boundary register: every capture decision works on this sampled copy.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            adc_data_q  <= '0;
            adc_valid_q <= 1'b0;
            con_adc_q   <= 1'b0;
            mode_q      <= 1'b0;
            arm_q       <= 1'b0;
            pkt_len_q   <= '0;
        end else begin
            adc_data_q  <= i_adc_data;
            adc_valid_q <= i_adc_valid;
            con_adc_q   <= i_con_adcside;
            mode_q      <= i_mode;
            arm_q       <= i_arm;
            pkt_len_q   <= i_pkt_len;
        end
    end

    // A disable seen at a packet boundary wins over a new sample, so no packet is ever cut short.
    always_comb begin
        len_eff_c = (pkt_len_q == '0) ? LEN_WIDTH'(1) : pkt_len_q;
        cur_len_c = (cnt_q == '0) ? len_eff_c : len_q;
        last_c    = (cnt_q == cur_len_c - LEN_WIDTH'(1));
        stop_c    = !con_adc_q && (cnt_q == '0);
        take_c    = (state_q == ST_RUN) && adc_valid_q && !stop_c;
        accept_c  = take_c && !fifo_full;
        drop_c    = take_c && fifo_full;
        load_c    = !fifo_empty && i_con_axisside && (!m_axis_tvalid || m_axis_tready);
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (con_adc_q && (!mode_q || arm_q)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (accept_c && last_c && mode_q) state_d = ST_DONE;
                else if (stop_c)                  state_d = ST_IDLE;
            end
            ST_DONE: begin
                if (arm_q)        state_d = ST_RUN;
                else if (!mode_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Beat counter advances only on accepted beats; length is frozen for the whole packet.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            cnt_q <= '0;
            len_q <= '0;
        end else if (accept_c) begin
            if (cnt_q == '0) len_q <= len_eff_c;
            cnt_q <= last_c ? '0 : cnt_q + LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            o_overflow   <= 1'b0;
            o_drop_count <= '0;
        end else if (arm_q) begin
            o_overflow   <= 1'b0;
            o_drop_count <= '0;
        end else if (drop_c) begin
            o_overflow <= 1'b1;
            if (o_drop_count != '1) o_drop_count <= o_drop_count + LEN_WIDTH'(1);
        end
    end

    adc_sample_fifo #(
        .DATA_WIDTH (FW),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (m_axis_aclk),
        .rst_n     (m_axis_aresetn),
        .wr_en     (accept_c),
        .wr_data   ({last_c, adc_data_q}),
        .rd_en     (load_c),
        .rd_data_c (fifo_rd_c),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (o_level)
    );

    // AXIS output register: a presented beat is held until it is taken.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load_c) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= fifo_rd_c[DW-1:0];
            m_axis_tlast  <= fifo_rd_c[DW];
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            o_busy <= 1'b0;
        end else begin
            o_busy <= (state_q != ST_IDLE) || !fifo_empty || m_axis_tvalid;
        end
    end

endmodule
